// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM data-port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Requester index: 0 = load/store unit, 1 = bootloader/debug loader.
  typedef logic req_idx_t;

  localparam int DEF_WORDS      = 128;
  localparam int DEF_LOCK_LIMIT = 8;

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way round-robin pick; when own_en_i is set only the owner may win.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   prio_i,
  input  logic       own_en_i,
  input  req_idx_t   owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (own_en_i) begin
      gnt_o[owner_i] = req_i[owner_i];
    end else if (req_i == 2'b11) begin
      gnt_o[prio_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with locked bursts for RAM data port 2; registered
// one-cycle ack with read data and fault flag.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WORDS      = DEF_WORDS,
  parameter int LOCK_LIMIT = DEF_LOCK_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        req_0,
  input  logic        we_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] wdata_0,
  input  logic [3:0]  mask_0,
  input  logic        lock_0,
  output logic        gnt_0,
  output logic        ack_0,
  output logic [31:0] rdata_0,
  output logic        err_0,
  // requester 1
  input  logic        req_1,
  input  logic        we_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_1,
  input  logic [3:0]  mask_1,
  input  logic        lock_1,
  output logic        gnt_1,
  output logic        ack_1,
  output logic [31:0] rdata_1,
  output logic        err_1,
  // RAM port 2
  output logic [31:0] ram_a,
  output logic [31:0] ram_di,
  output logic [3:0]  ram_m,
  output logic        ram_we,
  input  logic [31:0] ram_do,
  // debug view of the arbitration state
  output logic [1:0]  dbg_state_o,
  output logic        dbg_prio_o,
  output logic [7:0]  dbg_cnt_o
);

  localparam logic [29:0] WORDS_W = 30'(WORDS);
  localparam logic [7:0]  LIMIT_W = 8'(LOCK_LIMIT);

  // Handshake: a requester raises req_x with stable fields; gnt_x is
  // combinational in the cycle the access is taken, ack_x follows one cycle
  // later with rdata_x/err_x, and the requester may change fields after gnt_x.

  state_e      state_q, state_d;
  req_idx_t    prio_q, prio_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ack_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  req, lock, pick_gnt, gnt;
  logic        owned, keep, any, fault;
  req_idx_t    owner, prio_eff, sel;
  logic        sel_we, sel_lock;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_mask;

  assign req   = {req_1, req_0};
  assign lock  = {lock_1, lock_0};
  assign owned = (state_q != ARB);
  assign owner = (state_q == OWN1);
  assign keep  = owned && req[owner] && lock[owner] && (cnt_q < LIMIT_W);
  // Leaving a burst always favours the requester that was locked out.
  assign prio_eff = owned ? ~owner : prio_q;

  ram_arb_pick u_pick (
    .req_i    (req),
    .prio_i   (prio_eff),
    .own_en_i (keep),
    .owner_i  (owner),
    .gnt_o    (pick_gnt)
  );

  assign gnt   = reset ? 2'b00 : pick_gnt;
  assign gnt_0 = gnt[0];
  assign gnt_1 = gnt[1];
  assign any   = |gnt;
  assign sel   = gnt[1];

  assign sel_we    = sel ? we_1    : we_0;
  assign sel_lock  = sel ? lock_1  : lock_0;
  assign sel_addr  = sel ? addr_1  : addr_0;
  assign sel_wdata = sel ? wdata_1 : wdata_0;
  assign sel_mask  = sel ? mask_1  : mask_0;

  assign fault = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= WORDS_W);

  assign ram_a  = any ? sel_addr  : 32'd0;
  assign ram_di = any ? sel_wdata : 32'd0;
  assign ram_m  = any ? sel_mask  : 4'd0;
  assign ram_we = any && sel_we && !fault;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    if (!any) begin
      state_d = ARB;
      cnt_d   = 8'd0;
    end else if (keep) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      prio_d = ~sel;
      if (sel_lock) begin
        state_d = sel ? OWN1 : OWN0;
        cnt_d   = 8'd1;
      end else begin
        state_d = ARB;
        cnt_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
      ack_q   <= 2'b00;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      ack_q   <= gnt;
      rdata_q <= (any && !sel_we && !fault) ? ram_do : 32'd0;
      err_q   <= any && fault;
    end
  end

  assign ack_0   = ack_q[0];
  assign ack_1   = ack_q[1];
  assign rdata_0 = ack_q[0] ? rdata_q : 32'd0;
  assign rdata_1 = ack_q[1] ? rdata_q : 32'd0;
  assign err_0   = ack_q[0] && err_q;
  assign err_1   = ack_q[1] && err_q;

  assign dbg_state_o = state_q;
  assign dbg_prio_o  = prio_q;
  assign dbg_cnt_o   = cnt_q;

endmodule
